// File: rtl/loop_mem_ctrl.sv
// loop_mem_ctrl: record / play / overdub sequencer for the looper sample RAM.
// Each accepted sample_tick starts a short access sequence: phase A (read or
// record write) and, in overdub, phase B (mixed write-back). Commands are held
// in one pending slot and only take effect between sequences.
// Optional build macro LOOP_MEM_CTRL_DECAY_EN: overdub halves the existing
// content (arithmetic shift) before mixing in the new sample.
module loop_mem_ctrl #(
    parameter int AW = 13,
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_tick,
    input  logic [DW-1:0] in_sample,
    input  logic          cmd_rec,
    input  logic          cmd_play,
    input  logic          cmd_dub,
    input  logic          cmd_stop,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic [DW-1:0] out_sample,
    output logic          out_valid,
    output logic [1:0]    mode,
    output logic [AW:0]   loop_len,
    output logic          overrun
);

    typedef enum logic [1:0] {M_IDLE = 2'd0, M_REC = 2'd1, M_PLAY = 2'd2, M_DUB = 2'd3} mode_t;
    typedef enum logic [2:0] {C_NONE, C_STOP, C_REC, C_PLAY, C_DUB} cmd_t;

    mode_t         mode_q, n_mode;
    cmd_t          pend, new_cmd, eff_cmd;
    logic [AW-1:0] ptr, n_ptr, ptr_adv;
    logic [AW:0]   n_len;
    logic          ph_a, ph_b, busy;
    logic [DW-1:0] samp, old_term, dub_wd;

    localparam logic [AW:0]   FULL_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [DW-1:0] SAT_MAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_MIN  = {1'b1, {(DW-1){1'b0}}};

    // Signed add clamped to the DW-bit two's complement range.
    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        if (s[DW] != s[DW-1]) sat_add = s[DW] ? SAT_MIN : SAT_MAX;
        else                  sat_add = s[DW-1:0];
    endfunction

    assign busy     = ph_a | ph_b;
    assign mem_addr = ptr;
    assign mode     = mode_q;
    // Loop pointer advance; a one-sample loop keeps ptr pinned at 0.
    assign ptr_adv  = ({1'b0, ptr} == loop_len - 1'b1) ? '0 : ptr + 1'b1;

    // Overdub write data: existing content (optionally attenuated) plus new sample.
    always_comb begin
`ifdef LOOP_MEM_CTRL_DECAY_EN
        old_term = {mem_rd[DW-1], mem_rd[DW-1:1]};
`else
        old_term = mem_rd;
`endif
        dub_wd = sat_add(old_term, samp);
    end

    // Command priority (stop > rec > play > dub) and the mode change it implies.
    always_comb begin
        new_cmd = C_NONE;
        if      (cmd_stop) new_cmd = C_STOP;
        else if (cmd_rec)  new_cmd = C_REC;
        else if (cmd_play) new_cmd = C_PLAY;
        else if (cmd_dub)  new_cmd = C_DUB;
        eff_cmd = (new_cmd != C_NONE) ? new_cmd : pend;

        n_mode = mode_q;
        n_ptr  = ptr;
        n_len  = loop_len;
        case (mode_q)
            M_IDLE: begin
                if (eff_cmd == C_REC) begin
                    n_mode = M_REC;
                    n_ptr  = '0;
                end else if (eff_cmd == C_PLAY && loop_len != '0) begin
                    n_mode = M_PLAY;
                    n_ptr  = '0;
                end
            end
            M_REC: begin
                if (eff_cmd == C_STOP || eff_cmd == C_PLAY) begin
                    // Recording ends: whatever was written becomes the loop.
                    n_len  = {1'b0, ptr};
                    n_ptr  = '0;
                    n_mode = (eff_cmd == C_PLAY && ptr != '0) ? M_PLAY : M_IDLE;
                end
            end
            M_PLAY, M_DUB: begin
                if (eff_cmd == C_STOP) begin
                    n_mode = M_IDLE;
                    n_ptr  = '0;
                end else if (eff_cmd == C_REC) begin
                    n_mode = M_REC;
                    n_ptr  = '0;
                end else if (eff_cmd == C_DUB && mode_q == M_PLAY) begin
                    n_mode = M_DUB;
                end else if (eff_cmd == C_PLAY && mode_q == M_DUB) begin
                    n_mode = M_PLAY;
                end
            end
            default: n_mode = M_IDLE;
        endcase
    end

    // Mode FSM, access sequencer and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= M_IDLE;
            pend       <= C_NONE;
            ptr        <= '0;
            loop_len   <= '0;
            ph_a       <= 1'b0;
            ph_b       <= 1'b0;
            samp       <= '0;
            mem_we     <= 1'b0;
            mem_wd     <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            out_valid <= 1'b0;
            if (sample_tick && busy) overrun <= 1'b1;
            if (!busy) begin
                // Between sequences: apply the command, then start a new
                // sequence (in the new mode) if a tick is present.
                mode_q   <= n_mode;
                ptr      <= n_ptr;
                loop_len <= n_len;
                pend     <= C_NONE;
                if (sample_tick && n_mode != M_IDLE) begin
                    ph_a <= 1'b1;
                    samp <= in_sample;
                    if (n_mode == M_REC) begin
                        mem_we <= 1'b1;
                        mem_wd <= in_sample;
                    end
                end
            end else begin
                pend <= eff_cmd;
                if (ph_a) begin
                    ph_a <= 1'b0;
                    case (mode_q)
                        M_REC: begin
                            if (&ptr) begin
                                loop_len <= FULL_LEN;
                                ptr      <= '0;
                                mode_q   <= M_PLAY;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                        M_PLAY: begin
                            out_sample <= mem_rd;
                            out_valid  <= 1'b1;
                            ptr        <= ptr_adv;
                        end
                        M_DUB: begin
                            out_sample <= mem_rd;
                            out_valid  <= 1'b1;
                            mem_we     <= 1'b1;
                            mem_wd     <= dub_wd;
                            ph_b       <= 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    // Phase B: the mixed write lands this edge; move on.
                    ph_b <= 1'b0;
                    ptr  <= ptr_adv;
                end
            end
        end
    end

endmodule

// File: tb/tb_loop_mem_ctrl.sv
// tb_loop_mem_ctrl: randomized scoreboard bench for loop_mem_ctrl against a
// sample-level looper model (array RAM, modular loop pointer).
module tb_loop_mem_ctrl;
    localparam int AW = 13;
    localparam int DW = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          sample_tick = 1'b0;
    logic [DW-1:0] in_sample = '0;
    logic          cmd_rec = 1'b0, cmd_play = 1'b0, cmd_dub = 1'b0, cmd_stop = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd, mem_rd, out_sample;
    logic          out_valid, overrun;
    logic [1:0]    mode;
    logic [AW:0]   loop_len;

    logic [DW-1:0] phys_ram [DEPTH];

    loop_mem_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .in_sample(in_sample),
        .cmd_rec(cmd_rec), .cmd_play(cmd_play), .cmd_dub(cmd_dub), .cmd_stop(cmd_stop),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .out_sample(out_sample), .out_valid(out_valid), .mode(mode),
        .loop_len(loop_len), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on clock edge.
    assign mem_rd = phys_ram[mem_addr];
    always @(posedge clk) if (mem_we) phys_ram[mem_addr] <= mem_wd;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;

    typedef struct { int val; int cyc; } exp_t;
    exp_t sb[$];

    // Reference model state
    int ref_ram [DEPTH];
    int ref_mode = 0, ref_ptr = 0, ref_len = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 511) return 511;
        if (x < -512) return -512;
        return x;
    endfunction

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic model_cmd(input bit s, input bit r, input bit p, input bit d);
        int c;
        c = s ? 1 : r ? 2 : p ? 3 : d ? 4 : 0;
        case (ref_mode)
            0: if (c == 2) begin ref_mode = 1; ref_ptr = 0; end
               else if (c == 3 && ref_len != 0) begin ref_mode = 2; ref_ptr = 0; end
            1: if (c == 1 || c == 3) begin
                   ref_len = ref_ptr;
                   ref_mode = (c == 3 && ref_ptr != 0) ? 2 : 0;
                   ref_ptr = 0;
               end
            default: begin
                if (c == 1) begin ref_mode = 0; ref_ptr = 0; end
                else if (c == 2) begin ref_mode = 1; ref_ptr = 0; end
                else if (c == 4) ref_mode = 3;
                else if (c == 3) ref_mode = 2;
            end
        endcase
    endtask

    task automatic model_tick(input int v, input int n);
        int old;
        case (ref_mode)
            1: begin
                ref_ram[ref_ptr] = v;
                ref_ptr++;
                if (ref_ptr == DEPTH) begin ref_len = DEPTH; ref_ptr = 0; ref_mode = 2; end
            end
            2: begin
                sb.push_back('{ref_ram[ref_ptr], n + 2});
                ref_ptr = (ref_ptr + 1) % ref_len;
            end
            3: begin
                old = ref_ram[ref_ptr];
                sb.push_back('{old, n + 2});
`ifdef LOOP_MEM_CTRL_DECAY_EN
                ref_ram[ref_ptr] = sat((old >>> 1) + v);
`else
                ref_ram[ref_ptr] = sat(old + v);
`endif
                ref_ptr = (ref_ptr + 1) % ref_len;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_tick(input int v, input int gap);
        logic [DW-1:0] b;
        step();
        b = v[DW-1:0];
        sample_tick = 1'b1;
        in_sample = b;
        model_tick(sx(b), cyc);
        step();
        sample_tick = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_cmd(input bit s, input bit r, input bit p, input bit d,
                          input bit with_tick, input int v);
        logic [DW-1:0] b;
        step();
        b = v[DW-1:0];
        {cmd_stop, cmd_rec, cmd_play, cmd_dub} = {s, r, p, d};
        model_cmd(s, r, p, d);
        if (with_tick) begin
            sample_tick = 1'b1;
            in_sample = b;
            model_tick(sx(b), cyc);
        end
        step();
        {cmd_stop, cmd_rec, cmd_play, cmd_dub} = 4'b0;
        sample_tick = 1'b0;
        step();
    endtask

    task automatic chk_ram(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) chk($sformatf("ram[%0d]", i), sx(phys_ram[i]), ref_ram[i]);
    endtask

    // Monitor: every out_valid pops one expected sample and its due cycle.
    always @(negedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sample", sx(out_sample), e.val);
                chk("out_valid_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int w0, r, v;
        #1 reset_n = 1'b0;
        step();
        chk("rst_mode", int'(mode), 0);
        chk("rst_loop_len", int'(loop_len), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_wd", int'(mem_wd), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sample", int'(out_sample), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        step();
        reset_n = 1'b1;

        // Record 1..4 then stop
        do_cmd(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) do_tick(i, 1);
        do_cmd(1, 0, 0, 0, 0, 0);
        chk("rec_loop_len", int'(loop_len), 4);
        chk("rec_mode", int'(mode), 0);
        chk("rec_mem_addr", int'(mem_addr), 0);
        chk_ram(0, 3);

        // Play 9 ticks
        do_cmd(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) do_tick($urandom_range(0, 1023), 1 + (i % 2));
        repeat (3) step();

        // Overdub with 510 (saturates)
        do_cmd(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) do_tick(510, 1);
        repeat (3) step();
        chk("dub_mode", int'(mode), 3);
        chk_ram(0, 3);

        // Back-to-back ticks in DUB: second is dropped
        w0 = wr_cnt;
        step();
        sample_tick = 1'b1; in_sample = 10'd5;
        model_tick(5, cyc);
        step();
        in_sample = 10'd7;
        step();
        sample_tick = 1'b0;
        repeat (4) step();
        chk("overrun", int'(overrun), 1);
        chk("overrun_writes", wr_cnt - w0, 1);
        chk_ram(0, 3);

        // One-sample loop
        do_cmd(1, 0, 0, 0, 0, 0);
        do_cmd(0, 1, 0, 0, 0, 0);
        do_tick(-300, 1);
        do_cmd(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_tick(0, 1);
        chk("len1_loop_len", int'(loop_len), 1);
        chk("len1_mem_addr", int'(mem_addr), 0);

        // Rec then immediate play -> idle; play with empty loop ignored
        do_cmd(0, 1, 0, 0, 0, 0);
        do_cmd(0, 0, 1, 0, 0, 0);
        chk("empty_play_mode", int'(mode), 0);
        do_cmd(0, 0, 1, 0, 0, 0);
        chk("idle_play_ignored", int'(mode), 0);

        // Randomized command/tick mix
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            v = $urandom_range(0, 1023);
            if (r < 6) begin
                do_tick(v, $urandom_range(1, 3));
            end else begin
                do_cmd(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0),
                       ($urandom_range(0, 1) == 0), v);
                chk("rand_mode", int'(mode), ref_mode);
            end
        end
        repeat (3) step();
        chk("rand_ptr", int'(mem_addr), ref_ptr);

        // Full-depth record -> automatic PLAY
        do_cmd(1, 0, 0, 0, 0, 0);
        do_cmd(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("full_addr_last", int'(mem_addr), DEPTH - 1);
            do_tick($urandom_range(0, 1023), 1);
        end
        chk("full_mode", int'(mode), 2);
        chk("full_loop_len", int'(loop_len), DEPTH);
        chk("full_addr_wrap", int'(mem_addr), 0);
        for (int i = 0; i < 5; i++) do_tick(0, 1);
        repeat (3) step();

        // Reset during DUB phase B
        do_cmd(0, 0, 0, 1, 0, 0);
        step();
        sample_tick = 1'b1; in_sample = 10'd1;
        step();
        sample_tick = 1'b0;
        step();
        chk("phaseB_mem_we", int'(mem_we), 1);
        reset_n = 1'b0;
        #1;
        chk("rstB_mem_we", int'(mem_we), 0);
        chk("rstB_mode", int'(mode), 0);
        chk("rstB_loop_len", int'(loop_len), 0);
        step();
        reset_n = 1'b1;
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/loop_mem_ctrl.md
Name: loop_mem_ctrl

Overview:
- Sequences the single-port sample RAM (13-bit address, 10-bit data, combinational read, write on clock edge) for the looper.
- Records audio samples into RAM, plays back a loop of the recorded length, and overdubs (read-mix-write) on each sample strobe.
- Sits between the ADC/DAC sample path and the RAM; it is the only master driving RAM address, write enable and write data.

Parameters:
- AW, 13, RAM address width; RAM depth is 2^AW.
- DW, 10, sample width; samples are signed two's complement.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe, one per audio sample
- in_sample  in  DW  ADC sample; valid while sample_tick is high
- cmd_rec  in  1  one-cycle record request
- cmd_play  in  1  one-cycle play request
- cmd_dub  in  1  one-cycle overdub request
- cmd_stop  in  1  one-cycle stop request
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_wd  out  DW  RAM write data
- mem_rd  in  DW  RAM read data (combinational from mem_addr)
- out_sample  out  DW  playback sample to DAC
- out_valid  out  1  one-cycle strobe; out_sample updated
- mode  out  2  0=IDLE, 1=REC, 2=PLAY, 3=DUB
- loop_len  out  AW+1  recorded loop length in samples (0..2^AW)
- overrun  out  1  sticky flag; a tick arrived while busy

Behaviour:
- Reset (async assert, sync deassert): mode=IDLE, ptr=0, loop_len=0, mem_we=0, mem_wd=0, out_sample=0, out_valid=0, overrun=0, no pending command.
- mem_addr always equals ptr.
- Access sequencer, triggered by a tick at cycle T:
  - T+1 is phase A; T+2 is phase B, used only in DUB.
  - busy is high in T+1 and, in DUB, in T+2.
- REC:
  - Phase A: mem_we=1, mem_wd=in_sample (captured at T), then ptr++.
  - When ptr would reach 2^AW: loop_len=2^AW, ptr=0, mode changes to PLAY automatically.
- PLAY:
  - Phase A: mem_we=0; mem_rd is registered into out_sample, and out_valid=1 in T+2.
  - ptr increments; ptr==loop_len-1 wraps to 0.
- DUB:
  - Phase A: read exactly as in PLAY, with out_sample = old RAM content.
  - Phase B: mem_we=1, mem_wd = sat(old + in_sample).
  - sat is a signed add clamped to [-2^(DW-1), 2^(DW-1)-1], i.e. [-512, 511] at default.
  - ptr advances after phase B, with the same wrap rule as PLAY.
- IDLE: no RAM writes; out_valid stays 0.
- Commands:
  - Latched into a single pending slot.
  - Priority when several arrive together: stop > rec > play > dub. A newer command overwrites a pending one.
  - Applied in the first cycle with busy=0.
- Transitions:
  - IDLE: rec -> REC with ptr=0. play -> PLAY with ptr=0 only if loop_len!=0, otherwise ignored. dub and stop are ignored.
  - REC: stop -> IDLE with loop_len=ptr, ptr=0. play -> PLAY with loop_len=ptr, ptr=0; if ptr==0, go to IDLE instead. dub is ignored.
  - PLAY: stop -> IDLE with ptr=0. dub -> DUB with ptr held. rec -> REC with ptr=0 (discards the old loop).
  - DUB: stop -> IDLE with ptr=0. play -> PLAY with ptr held. rec -> REC with ptr=0.
- Boundary conditions:
  - A sample_tick while busy is dropped and sets overrun. overrun clears only on reset.
  - A tick and a command in the same idle cycle: the command is applied first, and the tick is serviced in the new mode.
  - loop_len=1 in PLAY: ptr stays 0.
  - Reset mid-write deasserts mem_we immediately. RAM contents are undefined after reset.

Optional Feature:
- Macro: LOOP_MEM_CTRL_DECAY_EN.
- When defined: in DUB phase B, mem_wd = sat((old >>> 1) + in_sample), so each overdub pass attenuates existing content by 6 dB using an arithmetic shift.
- When undefined: mem_wd = sat(old + in_sample), with no attenuation.
- PLAY output is unaffected in both cases.

Test Plan:
- Reset, cmd_rec, then 4 ticks with in_sample 1,2,3,4, then cmd_stop -> RAM[0..3]=1,2,3,4; loop_len=4; mode=0; ptr=0.
- Then cmd_play, then 9 ticks -> out_sample sequence 1,2,3,4,1,2,3,4,1; each out_valid exactly 2 cycles after its tick.
- Then cmd_dub and 4 ticks with in_sample=510 -> RAM[0..3]=511,511,511,511 (saturated). With DECAY_EN: 510,511,511,511.
- Two ticks 1 cycle apart in DUB -> second tick dropped, overrun=1, only one RAM write.
- Record 2^AW ticks -> auto PLAY, loop_len=8192, mem_addr wraps 8191 -> 0.
- Assert reset_n low during DUB phase B -> mem_we=0 within the same cycle, mode=0, loop_len=0.
